regfile_mp: RTL

- Parametrised successor to the 32x32 two-read/one-write register file.
- Configurable data width, register count and read-port count.
- Two write ports with fixed priority, write-through read bypass and an optional hardwired-zero register 0.
- Per-register busy scoreboard (reserve at issue, release at writeback) so the datapath controller can detect RAW hazards; it sits between decode (reads, reserve) and writeback (writes).

---
 rtl/regfile_mp_pkg.sv | 24 ++
 rtl/regfile_rdport.sv | 56 +++++
 rtl/regfile_mp.sv | 100 ++++++++++
 3 files changed

// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared defaults and helpers for the multi-port register file
package regfile_mp_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        WSEL_NONE,
        WSEL_P0,
        WSEL_P1
    } wsel_e;

    function automatic bit nregs_legal(input int nregs, input int addr_w);
        return (nregs > 0) && (nregs <= (1 << addr_w));
    endfunction

    // Port 1 wins whenever both write ports target the same register.
    function automatic wsel_e wr_select(input logic hit0, input logic hit1);
        if (hit1) return WSEL_P1;
        if (hit0) return WSEL_P0;
        return WSEL_NONE;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - one read port: storage mux, write-through bypass and busy flag
module regfile_rdport
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0]       ard,
    input  logic [NREGS*DATA_W-1:0] mem_flat,
    input  logic [NREGS-1:0]        busy_vec,
    input  logic [ADDR_W-1:0]       awr0,
    input  logic [DATA_W-1:0]       din0,
    input  logic                    wren0,
    input  logic [ADDR_W-1:0]       awr1,
    input  logic [DATA_W-1:0]       din1,
    input  logic                    wren1,
    output logic [DATA_W-1:0]       dout,
    output logic                    busy
);

    logic              in_range;
    logic              is_zero;
    logic              hit0;
    logic              hit1;
    logic [DATA_W-1:0] stored;
    logic              stored_busy;

    always_comb begin
        in_range    = int'(ard) < NREGS;
        is_zero     = (ZERO_REG != 0) && (ard == '0);
        hit0        = wren0 && (awr0 == ard);
        hit1        = wren1 && (awr1 == ard);
        stored      = '0;
        stored_busy = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            if (int'(ard) == r) begin
                stored      = mem_flat[r*DATA_W +: DATA_W];
                stored_busy = busy_vec[r];
            end
        end
        dout = '0;
        busy = 1'b0;
        // A writeback landing this cycle is forwarded and is no longer a hazard.
        if (in_range && !is_zero) begin
            case (wr_select(hit0, hit1))
                WSEL_P1: dout = din1;
                WSEL_P0: dout = din0;
                default: dout = stored;
            endcase
            busy = stored_busy && !(hit0 || hit1);
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised register file with two write ports and busy scoreboard
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [NRD*ADDR_W-1:0] Ard,
    output logic [NRD*DATA_W-1:0] Dout,
    output logic [NRD-1:0]        Busy,
    input  logic [ADDR_W-1:0]     Awr0,
    input  logic [DATA_W-1:0]     Din0,
    input  logic                  WrEn0,
    input  logic [ADDR_W-1:0]     Awr1,
    input  logic [DATA_W-1:0]     Din1,
    input  logic                  WrEn1,
    input  logic                  ResEn,
    input  logic [ADDR_W-1:0]     Ares
);

    // An oversized register count is clamped to what the address can reach.
    localparam int NR = nregs_legal(NREGS, ADDR_W) ? NREGS : (1 << ADDR_W);

    logic [DATA_W-1:0]    mem [NR];
    logic [NR-1:0]        busy_q;
    logic [NR-1:0]        hit0;
    logic [NR-1:0]        hit1;
    logic [NR-1:0]        hit_res;
    logic [NR*DATA_W-1:0] mem_flat;

    always_comb begin
        hit0    = '0;
        hit1    = '0;
        hit_res = '0;
        for (int r = 0; r < NR; r++) begin
            if (!((ZERO_REG != 0) && (r == 0))) begin
                hit0[r]    = WrEn0 && (int'(Awr0) == r);
                hit1[r]    = WrEn1 && (int'(Awr1) == r);
                hit_res[r] = ResEn && (int'(Ares) == r);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int r = 0; r < NR; r++) begin
                mem[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NR; r++) begin
                case (wr_select(hit0[r], hit1[r]))
                    WSEL_P1: mem[r] <= Din1;
                    WSEL_P0: mem[r] <= Din0;
                    default: ;
                endcase
                // A same-cycle reserve belongs to a newer producer, so it beats the clear.
                if (hit_res[r]) begin
                    busy_q[r] <= 1'b1;
                end else if (hit0[r] || hit1[r]) begin
                    busy_q[r] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        mem_flat = '0;
        for (int r = 0; r < NR; r++) begin
            mem_flat[r*DATA_W +: DATA_W] = mem[r];
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        regfile_rdport #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NREGS    (NR),
            .ZERO_REG (ZERO_REG)
        ) u_rdport (
            .ard      (Ard[i*ADDR_W +: ADDR_W]),
            .mem_flat (mem_flat),
            .busy_vec (busy_q),
            .awr0     (Awr0),
            .din0     (Din0),
            .wren0    (WrEn0),
            .awr1     (Awr1),
            .din1     (Din1),
            .wren1    (WrEn1),
            .dout     (Dout[i*DATA_W +: DATA_W]),
            .busy     (Busy[i])
        );
    end

endmodule
